rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 28 ++
 rtl/rst_seq_sync.sv | 27 ++
 rtl/rst_seq.sv | 141 ++++++++++++++
 tb/tb_rst_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer.
//   rst_seq_state_e : sequencer FSM states
//   rst_cause_e     : encoded cause of the most recent reset entry
//   entry_cause()   : prioritised cause selection when entering ASSERT
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rst_seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_LOCK = 2'd1,
    CAUSE_EXT  = 2'd2,
    CAUSE_SW   = 2'd3
  } rst_cause_e;

  // Lock loss outranks the push-button, which outranks software.
  function automatic rst_cause_e entry_cause(input logic locked_s, input logic ext_s);
    if (!locked_s) return CAUSE_LOCK;
    if (!ext_s)    return CAUSE_EXT;
    return CAUSE_SW;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop synchroniser with asynchronous clear to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear
//   d     : asynchronous input
//   q     : synchronised output (Stages edges of latency)
module rst_seq_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [Stages-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[Stages-2:0], d};
    end
  end

  assign q = ff[Stages-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: waits for a stable PLL lock and button, then releases
// NumOut active-low resets one after another, StageGap cycles apart.
//   clk_sys      : system clock
//   rst_sys_n    : asynchronous active-low reset of the sequencer itself
//   locked_i     : PLL lock (asynchronous)
//   ext_rst_ni   : push-button reset, active-low (asynchronous)
//   sw_rst_req_i : synchronous software reset request pulse
//   rst_no       : sequenced active-low resets, bit 0 released first
//   seq_done_o   : all resets released
//   rst_cause_o  : cause of the most recent reset entry (rst_cause_e)
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NumOut     = 3,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned HoldCycles = 1024,
  parameter int unsigned StageGap   = 16
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              locked_i,
  input  logic              ext_rst_ni,
  input  logic              sw_rst_req_i,
  output logic [NumOut-1:0] rst_no,
  output logic              seq_done_o,
  output logic [1:0]        rst_cause_o
);

  localparam int unsigned CntMax = (HoldCycles > StageGap) ? HoldCycles : StageGap;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(StageGap - 1);

  // Parameter legality
  if (NumOut == 0 || NumOut > 16) begin : g_bad_num_out
    $error("rst_seq: NumOut must be in 1..16");
  end
  if (SyncStages < 2 || SyncStages > 4) begin : g_bad_sync_stages
    $error("rst_seq: SyncStages must be in 2..4");
  end
  if (HoldCycles == 0) begin : g_bad_hold
    $error("rst_seq: HoldCycles must be at least 1");
  end
  if (StageGap == 0) begin : g_bad_gap
    $error("rst_seq: StageGap must be at least 1");
  end

  rst_seq_state_e    state, state_d;
  logic [CntW-1:0]   hold_cnt, hold_d;
  logic [CntW-1:0]   gap_cnt, gap_d;
  logic [NumOut-1:0] rst_d, rst_shift;
  logic [1:0]        cause_d;
  logic              locked_s, ext_s, good, abort;

  // The synchronisers restart from 0 on rst_sys_n, so removal of the
  // system reset only reaches the FSM through SyncStages clock edges.
  rst_seq_sync #(.Stages(SyncStages)) u_sync_locked (
    .clk   (clk_sys),
    .rst_n (rst_sys_n),
    .d     (locked_i),
    .q     (locked_s)
  );

  rst_seq_sync #(.Stages(SyncStages)) u_sync_ext (
    .clk   (clk_sys),
    .rst_n (rst_sys_n),
    .d     (ext_rst_ni),
    .q     (ext_s)
  );

  assign good  = locked_s & ext_s;
  assign abort = ~good | sw_rst_req_i;

  // Next release pattern: shift a 1 in at bit 0 (released bits stay high).
  assign rst_shift = NumOut'({rst_no, 1'b1});

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    rst_d   = rst_no;
    hold_d  = hold_cnt;
    gap_d   = gap_cnt;
    cause_d = rst_cause_o;

    if (state != ST_ASSERT && abort) begin
      state_d = ST_ASSERT;
      rst_d   = '0;
      hold_d  = '0;
      gap_d   = '0;
      cause_d = entry_cause(locked_s, ext_s);
    end else begin
      case (state)
        ST_ASSERT: begin
          rst_d  = '0;
          hold_d = '0;
          gap_d  = '0;
          if (!abort) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (hold_cnt == HoldLast) begin
            rst_d   = rst_shift;
            state_d = (&rst_shift) ? ST_RUN : ST_RELEASE;
          end else begin
            hold_d = (hold_cnt == '1) ? hold_cnt : hold_cnt + CntW'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_cnt == GapLast) begin
            rst_d = rst_shift;
            gap_d = '0;
            if (&rst_shift) state_d = ST_RUN;
          end else begin
            gap_d = (gap_cnt == '1) ? gap_cnt : gap_cnt + CntW'(1);
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_ASSERT;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state       <= ST_ASSERT;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      rst_no      <= '0;
      seq_done_o  <= 1'b0;
      rst_cause_o <= 2'(CAUSE_POR);
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_d;
      gap_cnt     <= gap_d;
      rst_no      <= rst_d;
      seq_done_o  <= &rst_d;
      rst_cause_o <= cause_d;
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq (NumOut=3, SyncStages=2, HoldCycles=4,
// StageGap=2): directed scenarios with fixed expectations, then random
// stimulus against a time-based reference model.
module tb_rst_seq;

  localparam int unsigned NUM_OUT = 3;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned HOLD    = 4;
  localparam int unsigned GAP     = 2;

  logic               clk_sys      = 1'b0;
  logic               rst_sys_n    = 1'b1;
  logic               locked_i     = 1'b1;
  logic               ext_rst_ni   = 1'b1;
  logic               sw_rst_req_i = 1'b0;
  logic [NUM_OUT-1:0] rst_no;
  logic               seq_done_o;
  logic [1:0]         rst_cause_o;

  int checks = 0;
  int passed = 0;

  rst_seq #(
    .NumOut     (NUM_OUT),
    .SyncStages (SYNC),
    .HoldCycles (HOLD),
    .StageGap   (GAP)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .locked_i     (locked_i),
    .ext_rst_ni   (ext_rst_ni),
    .sw_rst_req_i (sw_rst_req_i),
    .rst_no       (rst_no),
    .seq_done_o   (seq_done_o),
    .rst_cause_o  (rst_cause_o)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: the async inputs are seen SYNC edges late; once the
  // block leaves reset, m_run counts clean cycles and bit i is released
  // when m_run reaches HOLD + i*GAP.
  logic [SYNC-1:0] m_lk_dly, m_ex_dly;
  logic            m_held;
  int              m_run;
  logic [1:0]      m_cause;
  wire             m_lk   = m_lk_dly[SYNC-1];
  wire             m_ex   = m_ex_dly[SYNC-1];
  wire             m_good = m_lk & m_ex;

  always @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      m_lk_dly <= '0;
      m_ex_dly <= '0;
      m_held   <= 1'b1;
      m_run    <= 0;
      m_cause  <= 2'd0;
    end else begin
      m_lk_dly <= {m_lk_dly[SYNC-2:0], locked_i};
      m_ex_dly <= {m_ex_dly[SYNC-2:0], ext_rst_ni};
      if (m_held) begin
        if (m_good && !sw_rst_req_i) begin
          m_held <= 1'b0;
          m_run  <= 0;
        end
      end else if (!m_good || sw_rst_req_i) begin
        m_held  <= 1'b1;
        m_cause <= !m_lk ? 2'd1 : (!m_ex ? 2'd2 : 2'd3);
      end else if (m_run < 100000) begin
        m_run <= m_run + 1;
      end
    end
  end

  function automatic logic [NUM_OUT-1:0] exp_rst();
    logic [NUM_OUT-1:0] r;
    for (int i = 0; i < int'(NUM_OUT); i++)
      r[i] = !m_held && (m_run >= int'(HOLD + GAP * i));
    return r;
  endfunction

  task automatic test_reset();
    rst_sys_n = 1'b1;
    #1 rst_sys_n = 1'b0;
    #1;
    checks++;
    if (rst_no !== 3'b000 || seq_done_o !== 1'b0 || rst_cause_o !== 2'd0)
      $display("FAIL reset_async: rst_no=%b done=%b cause=%0d want 000/0/0", rst_no, seq_done_o, rst_cause_o);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_sys);
      locked_i = c[0];
      checks++;
      if (rst_no !== 3'b000 || seq_done_o !== 1'b0)
        $display("FAIL reset_hold: cycle %0d rst_no=%b done=%b want 000/0", c, rst_no, seq_done_o);
      else passed++;
    end
    locked_i = 1'b1;
  endtask

  // Release rst_sys_n with good inputs; bits rise at edges 7, 9, 11.
  task automatic test_power_on(input string tag);
    logic [NUM_OUT-1:0] exp;
    @(negedge clk_sys);
    rst_sys_n = 1'b0; locked_i = 1'b1; ext_rst_ni = 1'b1; sw_rst_req_i = 1'b0;
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk_sys);
      exp = {e >= 11, e >= 9, e >= 7};
      checks++;
      if (rst_no !== exp || seq_done_o !== (e >= 11) || rst_cause_o !== 2'd0)
        $display("FAIL %s edge %0d: rst_no=%b done=%b cause=%0d want %b/%0d/0",
                 tag, e, rst_no, seq_done_o, rst_cause_o, exp, e >= 11);
      else passed++;
    end
  endtask

  task automatic test_lock_loss();
    int n;
    @(negedge clk_sys);
    locked_i = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk_sys);
      if (e == 1) locked_i = 1'b1;
      checks++;
      if (rst_no !== ((e < 3) ? 3'b111 : 3'b000) || (e == 3 && rst_cause_o !== 2'd1))
        $display("FAIL lock_loss edge %0d: rst_no=%b cause=%0d want %b/1",
                 e, rst_no, rst_cause_o, (e < 3) ? 3'b111 : 3'b000);
      else passed++;
    end
    n = 0;
    while (seq_done_o !== 1'b1 && n < 40) begin @(negedge clk_sys); n++; end
    checks++;
    if (seq_done_o !== 1'b1 || rst_no !== 3'b111 || rst_cause_o !== 2'd1)
      $display("FAIL lock_recover: done=%b rst_no=%b cause=%0d after %0d cycles want 1/111/1",
               seq_done_o, rst_no, rst_cause_o, n);
    else passed++;
  endtask

  task automatic test_glitchy_button();
    int n;
    @(negedge clk_sys);
    ext_rst_ni = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk_sys);
      ext_rst_ni = (c % 3 != 0);
      if (c >= 3) begin
        checks++;
        if (rst_no !== 3'b000 || seq_done_o !== 1'b0)
          $display("FAIL glitch_hold cycle %0d: rst_no=%b done=%b want 000/0", c, rst_no, seq_done_o);
        else passed++;
      end
    end
    @(negedge clk_sys);
    ext_rst_ni = 1'b1;
    n = 0;
    while (seq_done_o !== 1'b1 && n < 40) begin @(negedge clk_sys); n++; end
    checks++;
    if (seq_done_o !== 1'b1 || rst_no !== 3'b111 || rst_cause_o !== 2'd2)
      $display("FAIL glitch_recover: done=%b rst_no=%b cause=%0d want 1/111/2", seq_done_o, rst_no, rst_cause_o);
    else passed++;
  endtask

  task automatic test_sw_reset();
    int n;
    @(negedge clk_sys);
    sw_rst_req_i = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk_sys);
      sw_rst_req_i = 1'b0;
      checks++;
      if (rst_no !== ((e >= 6) ? 3'b001 : 3'b000) || rst_cause_o !== 2'd3)
        $display("FAIL sw_reset edge %0d: rst_no=%b cause=%0d want %b/3",
                 e, rst_no, rst_cause_o, (e >= 6) ? 3'b001 : 3'b000);
      else passed++;
    end
    n = 0;
    while (seq_done_o !== 1'b1 && n < 40) begin @(negedge clk_sys); n++; end
    checks++;
    if (seq_done_o !== 1'b1 || rst_cause_o !== 2'd3)
      $display("FAIL sw_recover: done=%b cause=%0d want 1/3", seq_done_o, rst_cause_o);
    else passed++;
  endtask

  // Events coincide as the FSM sees them: the sw request is raised in the
  // cycle where the synchronised async drop first becomes visible.
  // k=0: lock+button, k=1: lock+sw, k=2: button+sw.
  task automatic test_coincident();
    int n;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      locked_i   = (k == 2);
      ext_rst_ni = (k == 1);
      @(negedge clk_sys);
      locked_i = 1'b1; ext_rst_ni = 1'b1;
      @(negedge clk_sys);
      sw_rst_req_i = (k != 0);
      @(negedge clk_sys);
      sw_rst_req_i = 1'b0;
      checks++;
      if (rst_no !== 3'b000 || rst_cause_o !== ((k == 2) ? 2'd2 : 2'd1))
        $display("FAIL coincident case %0d: rst_no=%b cause=%0d want 000/%0d",
                 k, rst_no, rst_cause_o, (k == 2) ? 2 : 1);
      else passed++;
      n = 0;
      while (seq_done_o !== 1'b1 && n < 40) begin @(negedge clk_sys); n++; end
      checks++;
      if (seq_done_o !== 1'b1)
        $display("FAIL coincident_recover case %0d: done=%b want 1", k, seq_done_o);
      else passed++;
    end
  endtask

  task automatic test_mid_release_abort();
    @(negedge clk_sys);
    sw_rst_req_i = 1'b1;
    @(negedge clk_sys);
    sw_rst_req_i = 1'b0;
    repeat (6) @(negedge clk_sys);
    checks++;
    if (rst_no !== 3'b001 || rst_cause_o !== 2'd3)
      $display("FAIL abort_pre: rst_no=%b cause=%0d want 001/3", rst_no, rst_cause_o);
    else passed++;
    #1 rst_sys_n = 1'b0;
    #1;
    checks++;
    if (rst_no !== 3'b000 || seq_done_o !== 1'b0 || rst_cause_o !== 2'd0)
      $display("FAIL abort_async: rst_no=%b done=%b cause=%0d want 000/0/0", rst_no, seq_done_o, rst_cause_o);
    else passed++;
    test_power_on("abort_restart");
  endtask

  task automatic test_random();
    logic [NUM_OUT-1:0] exp;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk_sys);
      exp = exp_rst();
      checks++;
      if (rst_no !== exp || seq_done_o !== &exp || rst_cause_o !== m_cause)
        $display("FAIL random cycle %0d: rst_no=%b done=%b cause=%0d want %b/%b/%0d",
                 c, rst_no, seq_done_o, rst_cause_o, exp, &exp, m_cause);
      else passed++;
      locked_i     = ($urandom_range(0, 39) != 0);
      ext_rst_ni   = ($urandom_range(0, 39) != 0);
      sw_rst_req_i = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_sys_n = 1'b0;
        #2 rst_sys_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on("power_on");
    test_lock_loss();
    test_glitchy_button();
    test_sw_reset();
    test_coincident();
    test_mid_release_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
